// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array and its operand feeder.
package systolic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_e;

  // Waves needed to push depth elements through the most-skewed lane.
  function automatic int num_waves(input int depth, input int h, input int w);
    return depth + ((h > w) ? h : w) - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_lane.sv
// One skewed operand lane: picks the element due on wave t, or drives 0 when idle.
module systolic_feeder_lane #(
  parameter int lane_p    = 0,
  parameter int depth_p   = 2,
  parameter int width_p   = 32,
  parameter int t_width_p = 2
) (
  input  logic                       en,
  input  logic [t_width_p-1:0]       t,
  input  logic [depth_p*width_p-1:0] ops,
  output logic [width_p-1:0]         data,
  output logic                       valid
);

  localparam logic [t_width_p-1:0] lane_c  = t_width_p'(lane_p);
  localparam logic [t_width_p-1:0] depth_c = t_width_p'(depth_p);

  logic [t_width_p-1:0] rel;

  assign rel   = t - lane_c;
  assign valid = en && (t >= lane_c) && (rel < depth_c);

  // Elements leave in descending k: wave offset rel carries k = depth-1-rel.
  always_comb begin
    data = '0;
    for (int k = 0; k < depth_p; k++) begin
      if (valid && (rel == t_width_p'(depth_p - 1 - k))) begin
        data = ops[k*width_p +: width_p];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Captures one A/B operand pair and streams it into the systolic array as skewed waves.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [width_p*array_height_p*depth_p-1:0]   a_i,
  input  logic [width_p*depth_p*array_width_p-1:0]    b_i,
  input  logic                                        v_i,
  output logic                                        ready_o,
  output logic [width_p*array_height_p-1:0]           row_o,
  output logic [array_height_p-1:0]                   row_valid_o,
  input  logic [array_height_p-1:0]                   row_ready_i,
  output logic [width_p*array_width_p-1:0]            col_o,
  output logic [array_width_p-1:0]                    col_valid_o,
  input  logic [array_width_p-1:0]                    col_ready_i,
  output logic                                        done_o,
  output feeder_state_e                               state_o
);

  localparam int waves_lp   = num_waves(depth_p, array_height_p, array_width_p);
  localparam int t_width_lp = $clog2(waves_lp + 1);
  localparam logic [t_width_lp-1:0] last_t_lp = t_width_lp'(waves_lp - 1);

  feeder_state_e state_q, state_n;
  logic [t_width_lp-1:0] t_q, t_n;
  logic ready_q, done_q, done_n;
  logic capture, sending, fire;
  logic [width_p*array_height_p*depth_p-1:0] a_q;
  logic [width_p*depth_p*array_width_p-1:0]  b_q;

  // Handshake: upstream pair transfers on v_i & ready_o. Toward the array each
  // lane transfers on valid & ready; a wave fires only when every valid lane is
  // ready, and valids/data are registered so they never depend on any ready.
  assign sending = (state_q == SEND);
  assign capture = (state_q == IDLE) && v_i && ready_q;
  assign fire    = sending
                   && (&(~row_valid_o | row_ready_i))
                   && (&(~col_valid_o | col_ready_i));

  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_n = SEND;
          t_n     = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (t_q == last_t_lp) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            t_n = t_q + t_width_lp'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ready_q lags reset release by one edge so ready_o stays low the cycle after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      t_q     <= t_n;
      ready_q <= (state_n == IDLE);
      done_q  <= done_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      a_q <= '0;
      b_q <= '0;
    end else if (capture) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign state_o = state_q;

  for (genvar r = 0; r < array_height_p; r++) begin : g_row
    systolic_feeder_lane #(
      .lane_p   (r),
      .depth_p  (depth_p),
      .width_p  (width_p),
      .t_width_p(t_width_lp)
    ) u_lane (
      .en   (sending),
      .t    (t_q),
      .ops  (a_q[r*depth_p*width_p +: depth_p*width_p]),
      .data (row_o[r*width_p +: width_p]),
      .valid(row_valid_o[r])
    );
  end

  for (genvar c = 0; c < array_width_p; c++) begin : g_col
    logic [depth_p*width_p-1:0] ops;

    // Gather column c of B so the lane sees it in k order like an A row.
    always_comb begin
      ops = '0;
      for (int k = 0; k < depth_p; k++) begin
        ops[k*width_p +: width_p] = b_q[width_p*(k*array_width_p + c) +: width_p];
      end
    end

    systolic_feeder_lane #(
      .lane_p   (c),
      .depth_p  (depth_p),
      .width_p  (width_p),
      .t_width_p(t_width_lp)
    ) u_lane (
      .en   (sending),
      .t    (t_q),
      .ops  (ops),
      .data (col_o[c*width_p +: width_p]),
      .valid(col_valid_o[c])
    );
  end

endmodule
